// File: rtl/serial_demux_1to8_if.sv
// Bus bundle for the 1-to-8 serial demultiplexer: serial input side, byte
// output handshake and status flags.
interface serial_demux_1to8_if;
  logic       din;
  logic       din_valid;
  logic       sof;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [2:0] lane;
  logic       overflow;
  logic       frame_err;
  logic       clr_err;

  modport master (
    output din, din_valid, sof, dout_ready, clr_err,
    input  dout, dout_valid, lane, overflow, frame_err
  );

  modport slave (
    input  din, din_valid, sof, dout_ready, clr_err,
    output dout, dout_valid, lane, overflow, frame_err
  );
endinterface

// File: rtl/serial_demux_1to8.sv
// Assembles LSB-first serial bits into bytes after a start-of-frame marker and
// hands them out over a valid/ready register with sticky overflow/framing flags.
//
// state   | meaning
// IDLE    | not frame-aligned; bits without sof are ignored, lane held at 0
// COLLECT | aligned; each accepted bit fills assembly[lane], lane advances
module serial_demux_1to8 (
  input logic              clk,
  input logic              rst_n,
  serial_demux_1to8_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] lane_q, lane_d;
  logic [7:0] asm_q, asm_d;
  logic [7:0] dout_q, dout_d;
  logic       dv_q, dv_d;
  logic       ovf_q, ovf_d;
  logic       ferr_q, ferr_d;
  logic       byte_done;
  logic       ovf_set;
  logic       ferr_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= 3'd0;
      asm_q   <= 8'h00;
      dout_q  <= 8'h00;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    asm_d     = asm_q;
    dout_d    = dout_q;
    dv_d      = dv_q;
    ovf_d     = ovf_q;
    ferr_d    = ferr_q;
    byte_done = 1'b0;
    ovf_set   = 1'b0;
    ferr_set  = 1'b0;

    if (bus.din_valid) begin
      if (bus.sof) begin
        // Realignment discards any partial byte; only a non-zero lane is an error.
        ferr_set = (state_q == COLLECT) && (lane_q != 3'd0);
        asm_d    = {7'b0, bus.din};
        lane_d   = 3'd1;
        state_d  = COLLECT;
      end else if (state_q == COLLECT) begin
        asm_d[lane_q] = bus.din;
        lane_d        = lane_q + 3'd1;
        byte_done     = (lane_q == 3'd7);
      end
    end

    if (byte_done) begin
      if (!dv_q || bus.dout_ready) begin
        dout_d = asm_d;
        dv_d   = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (dv_q && bus.dout_ready) begin
      dv_d = 1'b0;
    end

    // Set wins over a simultaneous clear.
    if (bus.clr_err) begin
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (ovf_set)  ovf_d  = 1'b1;
    if (ferr_set) ferr_d = 1'b1;
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.lane       = lane_q;
  assign bus.overflow   = ovf_q;
  assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_serial_demux_1to8.sv
// Self-checking bench for serial_demux_1to8: directed frames plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_serial_demux_1to8;

  logic clk;
  logic rst_n;
  serial_demux_1to8_if bus ();

  serial_demux_1to8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: collected bits kept as a queue, lane = number of bits held.
  bit         m_aligned;
  bit         m_bits[$];
  logic [7:0] m_dout;
  bit         m_dv;
  bit         m_ovf;
  bit         m_ferr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_aligned = 1'b0;
    m_bits.delete();
    m_dout = 8'h00;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic model_step(input bit din, input bit dv, input bit sof, input bit rdy, input bit clr);
    bit         done = 1'b0;
    bit         ovf_set = 1'b0;
    bit         ferr_set = 1'b0;
    logic [7:0] b = 8'h00;
    if (dv) begin
      if (sof) begin
        if (m_aligned && m_bits.size() != 0) ferr_set = 1'b1;
        m_bits.delete();
        m_bits.push_back(din);
        m_aligned = 1'b1;
      end else if (m_aligned) begin
        m_bits.push_back(din);
        if (m_bits.size() == 8) begin
          for (int i = 0; i < 8; i++) b[i] = m_bits[i];
          m_bits.delete();
          done = 1'b1;
        end
      end
    end
    if (done) begin
      if (!m_dv || rdy) begin
        m_dout = b;
        m_dv   = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (m_dv && rdy) begin
      m_dv = 1'b0;
    end
    if (clr) begin
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
    end
    if (ovf_set)  m_ovf  = 1'b1;
    if (ferr_set) m_ferr = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout_valid"}, bus.dout_valid, m_dv);
    chk({tag, ".dout"}, bus.dout, m_dout);
    chk({tag, ".lane"}, bus.lane, 32'(m_bits.size()));
    chk({tag, ".overflow"}, bus.overflow, m_ovf);
    chk({tag, ".frame_err"}, bus.frame_err, m_ferr);
  endtask

  // Called at a falling edge: drive, clock, update model, check at next falling edge.
  task automatic step(input bit din, input bit dv, input bit sof, input bit rdy, input bit clr, input string tag);
    bus.din        = din;
    bus.din_valid  = dv;
    bus.sof        = sof;
    bus.dout_ready = rdy;
    bus.clr_err    = clr;
    @(posedge clk);
    model_step(din, dv, sof, rdy, clr);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input int n, input bit rdy, input string tag);
    for (int i = 0; i < n; i++)
      step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), rdy, 1'b0, tag);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit rdy, input int gap, input string tag);
    for (int i = 0; i < 8; i++) begin
      step(b[i], 1'b1, (i == 0), rdy, 1'b0, tag);
      if (gap > 0 && i == 3) idle(gap, rdy, tag);
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int first_at;
  int second_at;
  int cyc;

  initial begin
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.sof = 1'b0;
    bus.dout_ready = 1'b0; bus.clr_err = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // LSB-first 1,0,1,0,0,1,0,1 -> 8'hA5, valid for a single cycle
    send_frame(8'hA5, 1'b1, 0, "a5");
    chk("a5.dout", bus.dout, 8'hA5);
    chk("a5.valid", bus.dout_valid, 1'b1);
    chk("a5.lane", bus.lane, 3'd0);
    idle(1, 1'b1, "a5_pop");
    chk("a5.valid_drop", bus.dout_valid, 1'b0);

    // Unaligned bits are ignored until sof
    async_reset("rst2");
    for (int i = 0; i < 5; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 1'b0, "noise");
      chk("noise.lane", bus.lane, 3'd0);
    end
    send_frame(8'h3C, 1'b1, 0, "3c");
    chk("3c.dout", bus.dout, 8'h3C);
    chk("3c.frame_err", bus.frame_err, 1'b0);
    idle(1, 1'b1, "3c_pop");

    // Overflow with consumer stalled
    send_frame(8'h11, 1'b0, 0, "f11");
    send_frame(8'h22, 1'b0, 0, "f22");
    chk("ovf.dout", bus.dout, 8'h11);
    chk("ovf.valid", bus.dout_valid, 1'b1);
    chk("ovf.flag", bus.overflow, 1'b1);
    idle(1, 1'b1, "ovf_pop");
    chk("ovf.consumed", bus.dout_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "ovf_clr");
    chk("ovf.cleared", bus.overflow, 1'b0);

    // Sof at lane 3 discards the partial byte
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "part");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "part");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "part");
    chk("part.lane", bus.lane, 3'd3);
    send_frame(8'hF0, 1'b1, 0, "f0");
    chk("f0.dout", bus.dout, 8'hF0);
    chk("f0.frame_err", bus.frame_err, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "ferr_clr");
    chk("ferr.cleared", bus.frame_err, 1'b0);

    // Back-to-back frames: outputs exactly 8 cycles apart
    first_at = -1; second_at = -1; cyc = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        logic [7:0] v;
        v = (f == 0) ? 8'h01 : 8'h02;
        step(v[i], 1'b1, (i == 0), 1'b1, 1'b0, "b2b");
        cyc++;
        if (bus.dout_valid && bus.dout == 8'h01 && first_at < 0) first_at = cyc;
        if (bus.dout_valid && bus.dout == 8'h02 && second_at < 0) second_at = cyc;
      end
    end
    chk("b2b.spacing", second_at - first_at, 8);
    chk("b2b.overflow", bus.overflow, 1'b0);
    idle(1, 1'b1, "b2b_pop");

    // Gaps mid-frame only delay the byte
    send_frame(8'h01, 1'b1, 3, "gap1");
    chk("gap1.dout", bus.dout, 8'h01);
    send_frame(8'h02, 1'b1, 5, "gap2");
    chk("gap2.dout", bus.dout, 8'h02);
    idle(1, 1'b1, "gap_pop");

    // Reset at lane 4 with a pending byte
    send_frame(8'h5A, 1'b0, 0, "pend");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 0), 1'b0, 1'b0, "pend_part");
    chk("pend.lane", bus.lane, 3'd4);
    chk("pend.valid", bus.dout_valid, 1'b1);
    async_reset("rst_mid");
    chk("rst_mid.valid", bus.dout_valid, 1'b0);
    for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 1'b0, "post_rst");
    chk("post_rst.valid", bus.dout_valid, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 19) == 0),
           "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
